// File: rtl/fm_audio_interp_pkg.sv
// rtl/fm_audio_interp_pkg.sv - shared types and constants for the FM audio interpolator
package fm_audio_pkg;

  // Interpolator control states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } fm_state_t;

  localparam int DEF_DATA_WIDTH  = 12;
  localparam int DEF_INTERP_LOG2 = 4;
  localparam int DEF_FIFO_DEPTH  = 4;

  // Occupancy counter width: must be able to represent DEPTH itself
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fm_audio_interp_fifo.sv
// rtl/fm_audio_interp_fifo.sv - small sample FIFO with fall-through head and flush
module fm_sample_fifo
  import fm_audio_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_FIFO_DEPTH
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_flush,
  input  logic                          i_push,
  input  logic [DATA_WIDTH-1:0]         i_data,
  input  logic                          i_pop,
  output logic [DATA_WIDTH-1:0]         o_head,
  output logic [level_width(DEPTH)-1:0] o_level,
  output logic                          o_empty,
  output logic                          o_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_width(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  w_push;
  logic                  w_pop;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == LW'(DEPTH));
  assign w_push  = i_push && !o_full && !i_flush;
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign o_head  = r_mem[r_rd_ptr];
  assign o_level = r_level;

  // Pointer and occupancy bookkeeping; push+pop together leaves the level unchanged
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sample storage; contents need no reset because the level gates every read
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fm_audio_interp.sv
// rtl/fm_audio_interp.sv - buffered linear interpolator feeding the FM modulator wave input
module fm_audio_interp
  import fm_audio_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int INTERP_LOG2 = DEF_INTERP_LOG2,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH
) (
  input  logic                               clk_in,
  input  logic                               RST,
  input  logic                               enable,
  input  logic [DATA_WIDTH-1:0]              s_data,
  input  logic                               s_valid,
  output logic                               s_ready,
  output logic [DATA_WIDTH-1:0]              wave_out,
  output logic                               underflow,
  input  logic                               underflow_clr,
  output logic [level_width(FIFO_DEPTH)-1:0] fifo_level
);

  localparam int DW = DATA_WIDTH;
  localparam int IL = INTERP_LOG2;
  localparam int PW = DATA_WIDTH + 1 + INTERP_LOG2;
  localparam logic [IL-1:0] PH_MAX = '1;

  fm_state_t      r_state;
  logic [DW-1:0]  r_prev;
  logic [DW-1:0]  r_cur;
  logic [IL-1:0]  r_phase;
  logic [DW-1:0]  r_wave;
  logic           r_underflow;
  logic           r_have_prev;

  logic [DW-1:0]          w_head;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_flush;
  logic signed [DW:0]     w_diff;
  logic signed [PW-1:0]   w_diff_x;
  logic signed [PW-1:0]   w_phase_x;
  logic signed [PW-1:0]   w_prod;
  logic signed [PW-1:0]   w_step;
  logic [DW-1:0]          w_interp;
  logic                   w_step_unused;

  // Reset is folded in so the handshake closes the moment RST rises
  assign s_ready   = enable && !RST && !w_full;
  assign w_push    = s_valid && s_ready;
  assign w_flush   = !enable;
  assign wave_out  = r_wave;
  assign underflow = r_underflow;

  fm_sample_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_in),
    .i_rst   (RST),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_data  (s_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_level (fifo_level),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  // Pop requests: only the FSM consumes samples, and never from an empty FIFO
  always_comb begin
    w_pop = 1'b0;
    if (enable && !w_empty) begin
      case (r_state)
        PRIME:   w_pop = 1'b1;
        RUN:     w_pop = (r_phase == PH_MAX);
        HOLD:    w_pop = 1'b1;
        default: w_pop = 1'b0;
      endcase
    end
  end

  // Interpolation: prev + floor((cur - prev) * phase / 2^IL); result lies between prev and cur
  assign w_diff    = $signed({r_cur[DW-1], r_cur}) - $signed({r_prev[DW-1], r_prev});
  assign w_diff_x  = {{IL{w_diff[DW]}}, w_diff};
  assign w_phase_x = {{(DW + 1){1'b0}}, r_phase};
  assign w_prod    = w_diff_x * w_phase_x;
  assign w_step    = w_prod >>> IL;
  assign w_interp  = r_prev + w_step[DW-1:0];
  assign w_step_unused = ^w_step[PW-1:DW];

  // Control FSM with registered sample, phase and underflow outputs
  always_ff @(posedge clk_in or posedge RST) begin
    if (RST) begin
      r_state     <= IDLE;
      r_prev      <= '0;
      r_cur       <= '0;
      r_phase     <= '0;
      r_wave      <= '0;
      r_underflow <= 1'b0;
      r_have_prev <= 1'b0;
    end else begin
      if (underflow_clr) r_underflow <= 1'b0;
      if (!enable) begin
        r_state     <= IDLE;
        r_prev      <= '0;
        r_cur       <= '0;
        r_phase     <= '0;
        r_wave      <= '0;
        r_have_prev <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_wave      <= '0;
            r_have_prev <= 1'b0;
            r_state     <= PRIME;
          end
          PRIME: begin
            r_wave <= '0;
            if (!w_empty) begin
              if (!r_have_prev) begin
                r_prev      <= w_head;
                r_have_prev <= 1'b1;
              end else begin
                r_cur       <= w_head;
                r_phase     <= '0;
                r_have_prev <= 1'b0;
                r_state     <= RUN;
              end
            end
          end
          RUN: begin
            r_wave <= w_interp;
            if (r_phase == PH_MAX) begin
              r_phase <= '0;
              if (!w_empty) begin
                r_prev <= r_cur;
                r_cur  <= w_head;
              end else begin
                r_state     <= HOLD;
                r_underflow <= 1'b1;
              end
            end else begin
              r_phase <= r_phase + IL'(1);
            end
          end
          HOLD: begin
            r_wave <= r_cur;
            if (!w_empty) begin
              r_prev  <= r_cur;
              r_cur   <= w_head;
              r_phase <= '0;
              r_state <= RUN;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/fm_audio_interp.md
Name: fm_audio_interp

Overview:
- Upstream feeder for the FM modulator. Buffers low-rate audio samples arriving over a valid/ready handshake.
- Linearly interpolates them by 2^INTERP_LOG2 and presents a registered, per-clock signed sample that drives the modulator's wave_in directly.
- Holds the last sample on underflow and flags it.

Parameters:
- DATA_WIDTH, 12: audio sample width (signed two's complement), equal to the modulator's INPUT_WIDTH.
- INTERP_LOG2, 4: log2 of the interpolation factor. Output clocks per input sample = 2^INTERP_LOG2. Range 1..8.
- FIFO_DEPTH, 4: input sample FIFO depth. Power of two, ≥2.

Ports:
- clk_in  input  1  system clock, single clock domain.
- RST  input  1  asynchronous, active-high reset.
- enable  input  1  run control; low = idle and flush.
- s_data  input  DATA_WIDTH  signed audio sample.
- s_valid  input  1  s_data valid.
- s_ready  output  1  FIFO can accept. Transfer occurs when s_valid && s_ready on a clk_in edge.
- wave_out  output  DATA_WIDTH  signed interpolated sample, registered.
- underflow  output  1  sticky; set when interpolation ran out of samples.
- underflow_clr  input  1  synchronous clear of underflow.
- fifo_level  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (async, RST=1): state IDLE. FIFO empty. prev=cur=0, phase=0, wave_out=0, underflow=0, fifo_level=0. s_ready=0 while RST high. Outputs return to their reset values immediately, without waiting for a clock edge.
- s_ready = enable && (fifo_level < FIFO_DEPTH), combinational. A push at full cannot occur.
- Simultaneous push and pop leaves the level unchanged.
- FIFO pop happens only under FSM control, and only when the FIFO is non-empty.
- State IDLE: wave_out=0, FIFO held empty, prev=cur=0. enable=1 -> PRIME.
- State PRIME:
  - While the FIFO is non-empty, pop one sample per cycle. The first pop loads prev; the second loads cur and goes to RUN with phase=0.
  - An empty FIFO waits in PRIME; wave_out stays 0.
- State RUN:
  - Each cycle, wave_out <= prev + ((cur - prev) * phase) >>> INTERP_LOG2, and phase increments.
  - When phase == 2^INTERP_LOG2-1 (last step) and the FIFO is non-empty: pop; prev<=cur, cur<=head, phase<=0, stay in RUN.
  - When phase is at max and the FIFO is empty: go to HOLD and set underflow=1.
- State HOLD:
  - wave_out <= cur every cycle.
  - When the FIFO becomes non-empty: pop; prev<=cur, cur<=head, phase<=0, go to RUN.
- enable=0 in any state -> IDLE on the next edge. The FIFO is flushed, prev/cur/phase clear, and wave_out=0 on that edge.
- Arithmetic:
  - diff is DATA_WIDTH+1 bits signed.
  - product is DATA_WIDTH+1+INTERP_LOG2 bits signed.
  - Shift is arithmetic, so rounding is floor toward -inf.
  - The result always lies between prev and cur, so it is truncated to DATA_WIDTH with no saturation needed.
- Latency: wave_out reflects the phase value of the previous cycle (one register stage). Sample n first appears as prev at phase 0 in the cycle after it is loaded into prev.
- Underflow: underflow_clr and a new underflow event in the same cycle -> underflow stays 1 (set wins).

Decomposition:
- Package fm_audio_pkg holds:
  - the FSM state enum (IDLE, PRIME, RUN, HOLD);
  - the fifo_level width function/constant;
  - the default INTERP_LOG2 and FIFO_DEPTH constants.
- One sub-module, fm_sample_fifo:
  - synchronous-read FIFO with first-word-fall-through head output;
  - async reset, flush input, push/pop/level.
- The interpolator FSM and datapath stay in fm_audio_interp.

Test Plan (INTERP_LOG2=4, DATA_WIDTH=12, FIFO_DEPTH=4):
- Ramp: push 0, 160, 160 with enable=1 -> after PRIME, wave_out runs 0,10,20,…,150, then holds 160 for 16 clocks. No underflow until the FIFO drains.
- Negative slope: prev=100, cur=-100 -> wave_out sequence 100, 87 (floor of -12.5), 75, 62, …, -88, then -100 when the next segment starts.
- Underflow: push only 2 samples (0, 160) -> after the 16-step ramp wave_out holds 160 and underflow=1. Push 320 -> ramp 160..310 resumes, underflow stays 1. Pulse underflow_clr -> 0.
- Backpressure: s_valid held high from enable, samples 1..10 -> fifo_level reaches 4 and s_ready=0. s_ready returns for exactly one accept per 16 clocks. No sample is lost or duplicated (check the output ramp endpoints in order).
- Async reset mid-RUN: assert RST between clock edges -> wave_out=0, s_ready=0, fifo_level=0 immediately. After release, with enable=1, the block restarts in PRIME.
- Enable drop: enable=0 during RUN with fifo_level=3 -> next edge wave_out=0 and fifo_level=0. Re-enable requires two fresh samples before a nonzero output appears.
